// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer peripheral on the data-memory bus.
// It shares we/a/wd/rd with dmem. Top-level decode uses sel to mux rd and to
// gate the dmem store strobe. It contains a prescaled free-running or
// auto-reload counter, a compare-match flag, an overflow flag and a level irq.
//
// Optional feature: define MMIO_TIMER_CAPTURE_EN to add a read-only CAPTURE
// register at offset 0x14. CAPTURE latches COUNT on every clock edge in which
// a load decodes to COUNT. Without the macro, offset 0x14 reads zero.
//
// Register map (word offsets a[4:2]; a[1:0] ignored):
//   0x00 CTRL     bit0 EN, bit1 AR (auto-reload), bit2 IE
//   0x04 PRESCALE 16 bits
//   0x08 COUNT
//   0x0C COMPARE
//   0x10 STATUS   bit0 MATCH, bit1 OVF, write-1-to-clear
//   0x14 CAPTURE  (optional, read-only)
//   others        read 0, writes ignored
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800,  // must be 32-byte aligned
  parameter int unsigned CNT_W     = 32              // 2..32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
`ifdef MMIO_TIMER_CAPTURE_EN
  localparam logic [2:0] OFF_CAPTURE  = 3'd5;
`endif

  // Architectural state
  logic             r_en;
  logic             r_ar;
  logic             r_ie;
  logic [15:0]      r_prescale;
  logic [15:0]      r_pcnt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_compare;
  logic             r_match;
  logic             r_ovf;
`ifdef MMIO_TIMER_CAPTURE_EN
  logic [CNT_W-1:0] r_capture;
`endif

  // Decode and datapath helpers
  logic             w_sel;
  logic [2:0]       w_off;
  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_wr_prescale;
  logic             w_wr_count;
  logic             w_wr_compare;
  logic             w_wr_status;
  logic             w_rd_count;
  logic             w_tick;
  logic             w_hit;
  logic             w_reload;
  logic             w_wrap;
  logic             w_set_match;
  logic             w_set_ovf;
  logic             w_clr_match;
  logic             w_clr_ovf;
  logic [CNT_W-1:0] w_count_inc;
  logic [CNT_W-1:0] w_wd_cnt;
  logic [31:0]      w_count_ext;
  logic [31:0]      w_compare_ext;
`ifdef MMIO_TIMER_CAPTURE_EN
  logic [31:0]      w_capture_ext;
`endif
  logic             w_unused_addr_bits;

  // Byte lane bits never matter: the window is word-access only.
  assign w_unused_addr_bits = &{1'b0, a[1:0]};

  // Window decode: the low five address bits select within a 32-byte window.
  assign w_sel = (a[31:5] == BASE_ADDR[31:5]);
  assign w_off = a[4:2];
  assign sel   = w_sel;

  // Store strobes per register; stores outside the window never reach state.
  assign w_wr          = we & w_sel;
  assign w_wr_ctrl     = w_wr & (w_off == OFF_CTRL);
  assign w_wr_prescale = w_wr & (w_off == OFF_PRESCALE);
  assign w_wr_count    = w_wr & (w_off == OFF_COUNT);
  assign w_wr_compare  = w_wr & (w_off == OFF_COMPARE);
  assign w_wr_status   = w_wr & (w_off == OFF_STATUS);
  assign w_rd_count    = ~we & w_sel & (w_off == OFF_COUNT);

  assign w_wd_cnt = wd[CNT_W-1:0];

  // The prescaler fires when its counter reaches PRESCALE; PRESCALE=0 fires
  // every enabled cycle.
  assign w_tick = r_en & (r_pcnt == r_prescale);

  // Counter step decisions for the current tick.
  assign w_hit       = (r_count == r_compare);
  assign w_reload    = r_ar & w_hit;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_wrap      = &r_count;

  // Hardware set and software clear of STATUS; the set wins on collision.
  assign w_set_match = w_tick & w_hit;
  assign w_set_ovf   = w_tick & ~w_reload & w_wrap;
  assign w_clr_match = w_wr_status & wd[0];
  assign w_clr_ovf   = w_wr_status & wd[1];

  // Interrupt is a pure function of registered state: no added latency.
  assign irq = r_ie & r_match;

  // CTRL register: clearing EN only stops ticks from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en <= 1'b0;
      r_ar <= 1'b0;
      r_ie <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en <= wd[0];
      r_ar <= wd[1];
      r_ie <= wd[2];
    end
  end

  // PRESCALE and COMPARE are plain software-written registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale <= 16'd0;
      r_compare  <= '0;
    end else begin
      if (w_wr_prescale) begin
        r_prescale <= wd[15:0];
      end
      if (w_wr_compare) begin
        r_compare <= w_wd_cnt;
      end
    end
  end

  // Prescale counter: restarts on a PRESCALE store, on a tick, or while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= 16'd0;
    end else if (w_wr_prescale || !r_en || w_tick) begin
      r_pcnt <= 16'd0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  // Main counter: a software store overrides whatever the tick would do.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= w_wd_cnt;
    end else if (w_tick) begin
      r_count <= w_reload ? '0 : w_count_inc;
    end
  end

  // STATUS flags: sticky until written with a 1, hardware set has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_set_match) begin
        r_match <= 1'b1;
      end else if (w_clr_match) begin
        r_match <= 1'b0;
      end
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end else if (w_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef MMIO_TIMER_CAPTURE_EN
  // Snapshot the value software sees on a COUNT load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_capture <= '0;
    end else if (w_rd_count) begin
      r_capture <= r_count;
    end
  end
`endif

  // Zero-extend the counter-width registers onto the 32-bit read bus.
  always_comb begin
    w_count_ext                = 32'd0;
    w_compare_ext              = 32'd0;
    w_count_ext[CNT_W-1:0]     = r_count;
    w_compare_ext[CNT_W-1:0]   = r_compare;
  end

`ifdef MMIO_TIMER_CAPTURE_EN
  // Zero-extend the capture register onto the read bus.
  always_comb begin
    w_capture_ext            = 32'd0;
    w_capture_ext[CNT_W-1:0] = r_capture;
  end
`endif

  // Combinational read mux; unselected or unused offsets return zero.
  always_comb begin
    rd = 32'd0;
    if (w_sel) begin
      case (w_off)
        OFF_CTRL:     rd = {29'd0, r_ie, r_ar, r_en};
        OFF_PRESCALE: rd = {16'd0, r_prescale};
        OFF_COUNT:    rd = w_count_ext;
        OFF_COMPARE:  rd = w_compare_ext;
        OFF_STATUS:   rd = {30'd0, r_ovf, r_match};
`ifdef MMIO_TIMER_CAPTURE_EN
        OFF_CAPTURE:  rd = w_capture_ext;
`endif
        default:      rd = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed and randomized checks of mmio_timer against a
// behavioural model of the register map, prescaler, counter and flags.
// Honours MMIO_TIMER_CAPTURE_EN the same way as the design.
`timescale 1ns/1ps
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_0800;
`ifdef MMIO_TIMER_CAPTURE_EN
  localparam logic [31:0] CAP_EXP = 32'd7;
`else
  localparam logic [31:0] CAP_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  mmio_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
    .rd(rd), .sel(sel), .irq(irq)
  );

  always #10 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit              m_en, m_ar, m_ie, m_match, m_ovf;
  int unsigned     m_pre, m_pcnt;
  longint unsigned m_cnt, m_cmp, m_cap;
  bit              t_sel, t_tick, t_hit, t_store;
  int              t_off;
  longint unsigned t_next;

  function automatic bit in_win(input logic [31:0] addr);
    return addr[31:5] == BASE[31:5];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en <= 0; m_ar <= 0; m_ie <= 0; m_match <= 0; m_ovf <= 0;
      m_pre <= 0; m_pcnt <= 0; m_cnt <= 0; m_cmp <= 0; m_cap <= 0;
    end else begin
      t_sel   = in_win(a);
      t_off   = int'(a[4:2]);
      t_store = we && t_sel;
      t_tick  = m_en && (m_pcnt == m_pre);
      t_hit   = (m_cnt == m_cmp);
      t_next  = m_cnt + 1;
      // prescaler
      if ((t_store && t_off == 1) || !m_en || t_tick) m_pcnt <= 0;
      else m_pcnt <= m_pcnt + 1;
      // counter
      if (t_store && t_off == 2) m_cnt <= longint'(wd);
      else if (t_tick) m_cnt <= (m_ar && t_hit) ? 0 : t_next % 64'h1_0000_0000;
      // flags: set on event, else cleared by writing 1
      m_match <= (t_tick && t_hit) || (m_match && !(t_store && t_off == 4 && wd[0]));
      m_ovf   <= (t_tick && !(m_ar && t_hit) && t_next == 64'h1_0000_0000)
                 || (m_ovf && !(t_store && t_off == 4 && wd[1]));
      if (t_store && t_off == 0) begin
        m_en <= wd[0]; m_ar <= wd[1]; m_ie <= wd[2];
      end
      if (t_store && t_off == 1) m_pre <= wd & 32'hFFFF;
      if (t_store && t_off == 3) m_cmp <= longint'(wd);
      if (!we && t_sel && t_off == 2) m_cap <= m_cnt;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] r;
    r = 32'd0;
    if (in_win(addr)) begin
      case (addr[4:2])
        3'd0: r = {29'd0, m_ie, m_ar, m_en};
        3'd1: r = m_pre;
        3'd2: r = m_cnt[31:0];
        3'd3: r = m_cmp[31:0];
        3'd4: r = {30'd0, m_ovf, m_match};
`ifdef MMIO_TIMER_CAPTURE_EN
        3'd5: r = m_cap[31:0];
`endif
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag);
    check(tag, {31'd0, irq}, {31'd0, m_ie & m_match});
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr);
    we = 1'b0; a = addr; #1;
    check(tag, rd, model_read(addr));
    check({tag, ".sel"}, {31'd0, sel}, {31'd0, in_win(addr)});
  endtask

  task automatic rd_const(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    we = 1'b0; a = addr; #1;
    check(tag, rd, exp);
    check({tag, ".model"}, rd, model_read(addr));
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    we = 1'b0; a = 32'd0; #1;
    chk_irq("wr.irq");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      we = 1'b0; a = 32'd0;
      @(negedge clk); #1;
      chk_irq("idle.irq");
    end
  endtask

  logic [31:0] seq3 [7];
  logic        irq3 [7];
  logic [31:0] addr_r, data_r;
  int          op, off;

  initial begin
    seq3 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};
    irq3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    rd_const("rst.count", BASE + 32'h8, 32'd0);
    check("rst.irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: reset mid-count
    wr(BASE + 32'h4, 32'd0);
    wr(BASE + 32'h8, 32'h1234);
    rd_const("t1.count_set", BASE + 32'h8, 32'h1234);
    wr(BASE + 32'hC, 32'h1234);
    wr(BASE + 32'h0, 32'h5);
    idle(3);
    #3 reset = 1'b1; #1;
    check("t1.irq_in_reset", {31'd0, irq}, 32'd0);
    rd_const("t1.ctrl", BASE + 32'h0, 32'd0);
    rd_const("t1.count", BASE + 32'h8, 32'd0);
    rd_const("t1.compare", BASE + 32'hC, 32'd0);
    rd_const("t1.status", BASE + 32'h10, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    rd_const("t1.count_after", BASE + 32'h8, 32'd0);
    rd_const("t1.ctrl_after", BASE + 32'h0, 32'd0);

    // 2: prescaled count
    wr(BASE + 32'h4, 32'd3);
    wr(BASE + 32'h0, 32'h1);
    idle(4);
    rd_const("t2.count4", BASE + 32'h8, 32'd1);
    idle(16);
    rd_const("t2.count20", BASE + 32'h8, 32'd5);
    wr(BASE + 32'h0, 32'h0);

    // 3: auto-reload, match, irq, W1C
    wr(BASE + 32'h8, 32'd0);
    wr(BASE + 32'h4, 32'd0);
    wr(BASE + 32'hC, 32'd4);
    wr(BASE + 32'h10, 32'h3);
    wr(BASE + 32'h0, 32'h7);
    for (int i = 0; i < 7; i++) begin
      rd_const($sformatf("t3.count%0d", i), BASE + 32'h8, seq3[i]);
      check($sformatf("t3.irq%0d", i), {31'd0, irq}, {31'd0, irq3[i]});
      @(negedge clk);
    end
    wr(BASE + 32'h10, 32'h1);
    rd_const("t3.status_clr", BASE + 32'h10, 32'd0);
    check("t3.irq_clr", {31'd0, irq}, 32'd0);
    idle(1);
    rd_const("t3.count_at4", BASE + 32'h8, 32'd4);
    // 5b: clear collides with a match tick
    wr(BASE + 32'h10, 32'h1);
    rd_const("t5.match_kept", BASE + 32'h10, 32'd1);
    check("t5.irq_kept", {31'd0, irq}, 32'd1);
    wr(BASE + 32'h0, 32'h0);
    wr(BASE + 32'h10, 32'h3);

    // 4: overflow
    wr(BASE + 32'hC, 32'h10);
    wr(BASE + 32'h8, 32'hFFFF_FFFE);
    wr(BASE + 32'h0, 32'h1);
    idle(1);
    rd_const("t4.count_max", BASE + 32'h8, 32'hFFFF_FFFF);
    idle(1);
    rd_const("t4.count_wrap", BASE + 32'h8, 32'd0);
    rd_const("t4.status", BASE + 32'h10, 32'h2);
    check("t4.irq", {31'd0, irq}, 32'd0);

    // 5a: store beats tick; EN clear still lets that cycle's tick apply
    wr(BASE + 32'h8, 32'h100);
    rd_const("t5.count_wr", BASE + 32'h8, 32'h100);
    wr(BASE + 32'h0, 32'h0);
    idle(2);
    rd_const("t5.count_hold", BASE + 32'h8, 32'h101);

    // 6: decode
    wr(BASE + 32'h18, 32'hFFFF_FFFF);
    wr(32'h0000_0064, 32'hFFFF_FFFF);
    rd_const("t6.out_rd", 32'h0000_0064, 32'd0);
    check("t6.out_sel", {31'd0, sel}, 32'd0);
    rd_const("t6.hole", BASE + 32'h1C, 32'd0);
    idle(1);
    rd_const("t6.ctrl", BASE + 32'h0, 32'd0);
    rd_const("t6.pre", BASE + 32'h4, 32'd0);
    rd_const("t6.count", BASE + 32'h8, 32'h101);
    rd_const("t6.cmp", BASE + 32'hC, 32'h10);
    rd_const("t6.status", BASE + 32'h10, 32'h2);
    wr(BASE + 32'h8, 32'd7);
    rd_chk("t6.count7", BASE + 32'h8);
    @(negedge clk);
    rd_const("t6.capture", BASE + 32'h14, CAP_EXP);

    // random phase
    wr(BASE + 32'h0, 32'h7);
    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 9));
      off = int'($urandom_range(0, 7));
      addr_r = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
      if (op < 2) begin
        data_r = $urandom();
        case (off)
          1: data_r = (data_r & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
          2: data_r = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8))
                                                  : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          3: data_r = 32'($urandom_range(0, 8));
          default: ;
        endcase
        wr(addr_r, data_r);
      end else if (op == 2) begin
        addr_r = $urandom();
        if (in_win(addr_r)) addr_r = addr_r ^ 32'h0010_0000;
        wr(addr_r, $urandom());
      end else if (op < 6) begin
        rd_chk($sformatf("rnd%0d.rd", i), addr_r);
        @(negedge clk);
      end else begin
        idle(1);
      end
    end
    for (int o = 0; o < 8; o++) begin
      rd_chk($sformatf("final.off%0d", o), BASE + 32'(o * 4));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
